// File: rtl/lfu_victim_select.sv
// LFU victim-select controller: bumps the hit way's counter, or picks and clears a victim way on a miss.
// Optional global counter aging is compiled in with the LFU_AGING_EN macro.
module lfu_victim_select #(
  parameter int BITS_DIRECT  = 10,
  parameter int SIZE_COUNTER = 4,
  parameter int AGE_PERIOD   = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_hit,
  input  logic [1:0]              req_way,
  input  logic [BITS_DIRECT-1:0]  req_addr,
  input  logic [3:0]              valid_mask,
  input  logic [SIZE_COUNTER-1:0] count_in0,
  input  logic [SIZE_COUNTER-1:0] count_in1,
  input  logic [SIZE_COUNTER-1:0] count_in2,
  input  logic [SIZE_COUNTER-1:0] count_in3,
  output logic                    enable,
  output logic [3:0]              line_reset,
  output logic [3:0]              line_sum,
  output logic [BITS_DIRECT-1:0]  address,
  output logic                    count_read,
  output logic                    gen_reset,
  output logic                    resp_valid,
  output logic [1:0]              resp_way
);

  if (AGE_PERIOD < 2 || AGE_PERIOD > 256) begin : g_bad_age_period
    $error("AGE_PERIOD must be in 2..256");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CMP,
    S_UPD,
    S_AGE
  } state_t;

  state_t                   state_q, state_d;
  logic                     hit_q, hit_d;
  logic [1:0]               way_q, way_d;
  logic [BITS_DIRECT-1:0]   addr_q, addr_d;
  logic [3:0]               valid_q, valid_d;
  logic [1:0]               victim;
  logic [SIZE_COUNTER-1:0]  min_cnt;
  logic [SIZE_COUNTER-1:0]  cnt [4];

`ifdef LFU_AGING_EN
  logic [7:0]               acc_q, acc_d;
  logic                     age_pend_q, age_pend_d;
  logic [8:0]               acc_inc;
`endif

  assign cnt[0]   = count_in0;
  assign cnt[1]   = count_in1;
  assign cnt[2]   = count_in2;
  assign cnt[3]   = count_in3;
  assign address  = addr_q;
  assign resp_way = way_q;

  // Invalid ways win outright; otherwise strict less-than keeps ties on the lowest index.
  always_comb begin
    victim  = 2'd0;
    min_cnt = cnt[0];
    if (!(&valid_q)) begin
      for (int i = 3; i >= 0; i--) begin
        if (!valid_q[i]) victim = 2'(i);
      end
    end else begin
      for (int i = 1; i < 4; i++) begin
        if (cnt[i] < min_cnt) begin
          min_cnt = cnt[i];
          victim  = 2'(i);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hit_d      = hit_q;
    way_d      = way_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    req_ready  = 1'b0;
    enable     = 1'b0;
    line_reset = 4'b0000;
    line_sum   = 4'b0000;
    count_read = 1'b0;
    gen_reset  = 1'b0;
    resp_valid = 1'b0;
`ifdef LFU_AGING_EN
    acc_d      = acc_q;
    age_pend_d = age_pend_q;
    acc_inc    = {1'b0, acc_q} + 9'd1;
`endif
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          hit_d   = req_hit;
          way_d   = req_way;
          addr_d  = req_addr;
          valid_d = valid_mask;
          state_d = req_hit ? S_UPD : S_READ;
`ifdef LFU_AGING_EN
          if (acc_inc == 9'(AGE_PERIOD)) begin
            acc_d      = 8'd0;
            age_pend_d = 1'b1;
          end else begin
            acc_d = acc_inc[7:0];
          end
`endif
        end
      end
      S_READ: begin
        count_read = 1'b1;
        state_d    = S_CMP;
      end
      S_CMP: begin
        way_d   = victim;
        state_d = S_UPD;
      end
      S_UPD: begin
        enable     = 1'b1;
        resp_valid = 1'b1;
        if (hit_q) line_sum   = 4'b0001 << way_q;
        else       line_reset = 4'b0001 << way_q;
        state_d = S_IDLE;
`ifdef LFU_AGING_EN
        if (age_pend_q) begin
          age_pend_d = 1'b0;
          state_d    = S_AGE;
        end
`endif
      end
      S_AGE: begin
`ifdef LFU_AGING_EN
        gen_reset = 1'b1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hit_q      <= 1'b0;
      way_q      <= 2'd0;
      addr_q     <= '0;
      valid_q    <= 4'b0000;
`ifdef LFU_AGING_EN
      acc_q      <= 8'd0;
      age_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hit_q      <= hit_d;
      way_q      <= way_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
`ifdef LFU_AGING_EN
      acc_q      <= acc_d;
      age_pend_q <= age_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_lfu_victim_select.sv
// Directed bench for lfu_victim_select: hit/miss timing, victim rule, busy backpressure, reset abort, aging.
module tb_lfu_victim_select;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready, req_hit;
  logic [1:0] req_way;
  logic [9:0] req_addr;
  logic [3:0] valid_mask;
  logic [3:0] count_in0, count_in1, count_in2, count_in3;
  logic       enable;
  logic [3:0] line_reset, line_sum;
  logic [9:0] address;
  logic       count_read, gen_reset, resp_valid;
  logic [1:0] resp_way;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lfu_victim_select #(
    .BITS_DIRECT (10),
    .SIZE_COUNTER(4),
    .AGE_PERIOD  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_hit   (req_hit),
    .req_way   (req_way),
    .req_addr  (req_addr),
    .valid_mask(valid_mask),
    .count_in0 (count_in0),
    .count_in1 (count_in1),
    .count_in2 (count_in2),
    .count_in3 (count_in3),
    .enable    (enable),
    .line_reset(line_reset),
    .line_sum  (line_sum),
    .address   (address),
    .count_read(count_read),
    .gen_reset (gen_reset),
    .resp_valid(resp_valid),
    .resp_way  (resp_way)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    req_valid = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Returns at the negedge of the UPD cycle (acceptance + 1).
  task automatic hit_op(input logic [1:0] way, input logic [9:0] addr);
    req_valid = 1'b1;
    req_hit   = 1'b1;
    req_way   = way;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
  endtask

  // Returns at the negedge of the UPD cycle (acceptance + 3).
  task automatic miss_op(input logic [3:0] mask, input logic [3:0] c0, input logic [3:0] c1,
                         input logic [3:0] c2, input logic [3:0] c3);
    req_valid  = 1'b1;
    req_hit    = 1'b0;
    req_way    = 2'd3;
    req_addr   = 10'h155;
    valid_mask = mask;
    count_in0  = c0;
    count_in1  = c1;
    count_in2  = c2;
    count_in3  = c3;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    req_valid  = 1'b0;
    req_hit    = 1'b0;
    req_way    = 2'd0;
    req_addr   = 10'd0;
    valid_mask = 4'hF;
    count_in0  = 4'd0;
    count_in1  = 4'd0;
    count_in2  = 4'd0;
    count_in3  = 4'd0;
    @(negedge clk);
    do_reset();

    // Reset values
    chk("rst_ready", req_ready, 1);
    chk("rst_enable", enable, 0);
    chk("rst_line_sum", line_sum, 0);
    chk("rst_line_reset", line_reset, 0);
    chk("rst_count_read", count_read, 0);
    chk("rst_gen_reset", gen_reset, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_way", resp_way, 0);
    chk("rst_address", address, 0);

    // Hit, latency 1
    hit_op(2'd2, 10'h005);
    chk("hit_enable", enable, 1);
    chk("hit_line_sum", line_sum, 4'b0100);
    chk("hit_line_reset", line_reset, 0);
    chk("hit_resp_valid", resp_valid, 1);
    chk("hit_resp_way", resp_way, 2);
    chk("hit_address", address, 10'h005);
    chk("hit_ready_busy", req_ready, 0);
    tick();
    chk("hit_idle_ready", req_ready, 1);
    chk("hit_idle_enable", enable, 0);
    chk("hit_idle_resp", resp_valid, 0);
    chk("hit_addr_held", address, 10'h005);

    // Miss, all valid, counts {3,1,7,1}: tie between ways 1 and 3 goes to 1
    do_reset();
    req_valid  = 1'b1;
    req_hit    = 1'b0;
    req_way    = 2'd3;
    req_addr   = 10'h02A;
    valid_mask = 4'hF;
    count_in0  = 4'd3;
    count_in1  = 4'd1;
    count_in2  = 4'd7;
    count_in3  = 4'd1;
    tick();
    req_valid = 1'b0;
    chk("miss_read_strobe", count_read, 1);
    chk("miss_read_enable", enable, 0);
    chk("miss_read_ready", req_ready, 0);
    tick();
    chk("miss_cmp_strobe", count_read, 0);
    chk("miss_cmp_resp", resp_valid, 0);
    chk("miss_cmp_enable", enable, 0);
    tick();
    chk("miss_upd_line_reset", line_reset, 4'b0010);
    chk("miss_upd_line_sum", line_sum, 0);
    chk("miss_upd_enable", enable, 1);
    chk("miss_upd_resp_valid", resp_valid, 1);
    chk("miss_upd_resp_way", resp_way, 1);
    chk("miss_upd_address", address, 10'h02A);
    tick();
    chk("miss_idle_resp", resp_valid, 0);
    chk("miss_idle_ready", req_ready, 1);

    // Invalid way overrides counts
    do_reset();
    miss_op(4'b1011, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("inv_resp_way", resp_way, 2);
    chk("inv_line_reset", line_reset, 4'b0100);

    do_reset();
    miss_op(4'b0110, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("inv0_resp_way", resp_way, 0);

    do_reset();
    miss_op(4'b0111, 4'd0, 4'd9, 4'd9, 4'd15);
    chk("inv3_resp_way", resp_way, 3);
    chk("inv3_line_reset", line_reset, 4'b1000);

    // Minimum count selection
    do_reset();
    miss_op(4'hF, 4'd5, 4'd2, 4'd2, 4'd9);
    chk("tie12_resp_way", resp_way, 1);

    do_reset();
    miss_op(4'hF, 4'd4, 4'd4, 4'd4, 4'd3);
    chk("min3_resp_way", resp_way, 3);
    chk("min3_line_reset", line_reset, 4'b1000);

    do_reset();
    miss_op(4'hF, 4'd15, 4'd0, 4'd15, 4'd15);
    chk("min1_zero_resp_way", resp_way, 1);

    // All counts equal with req_valid held high: next request accepted only at T+4
    do_reset();
    req_valid  = 1'b1;
    req_hit    = 1'b0;
    req_way    = 2'd3;
    req_addr   = 10'h3FF;
    valid_mask = 4'hF;
    count_in0  = 4'd15;
    count_in1  = 4'd15;
    count_in2  = 4'd15;
    count_in3  = 4'd15;
    tick();
    chk("held_read_ready", req_ready, 0);
    tick();
    chk("held_cmp_ready", req_ready, 0);
    req_addr = 10'h011;
    tick();
    chk("held_upd_ready", req_ready, 0);
    chk("held_upd_resp_way", resp_way, 0);
    chk("held_upd_line_reset", line_reset, 4'b0001);
    chk("held_upd_address", address, 10'h3FF);
    req_hit = 1'b1;
    req_way = 2'd3;
    tick();
    chk("held_idle_ready", req_ready, 1);
    chk("held_idle_resp", resp_valid, 0);
    tick();
    req_valid = 1'b0;
    chk("held_second_resp", resp_valid, 1);
    chk("held_second_way", resp_way, 3);
    chk("held_second_sum", line_sum, 4'b1000);
    chk("held_second_addr", address, 10'h011);
    tick();

    // Reset during CMP aborts the miss
    do_reset();
    req_valid  = 1'b1;
    req_hit    = 1'b0;
    req_addr   = 10'h0C3;
    valid_mask = 4'hF;
    count_in0  = 4'd2;
    count_in1  = 4'd8;
    count_in2  = 4'd1;
    count_in3  = 4'd8;
    tick();
    req_valid = 1'b0;
    tick();
    chk("abort_in_cmp", count_read, 0);
    reset = 1'b1;
    tick();
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_enable", enable, 0);
    chk("abort_line_reset", line_reset, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_address", address, 0);
    chk("abort_resp_way", resp_way, 0);
    reset = 1'b0;
    tick();
    chk("abort_after_resp", resp_valid, 0);
    chk("abort_after_enable", enable, 0);

`ifdef LFU_AGING_EN
    // AGE_PERIOD=4: AGE cycle after the 4th UPD
    do_reset();
    for (int n = 0; n < 3; n++) begin
      hit_op(2'(n), 10'(n));
      chk("age_hit_resp", resp_valid, 1);
      tick();
      chk("age_no_gen_reset", gen_reset, 0);
      chk("age_idle_ready", req_ready, 1);
    end
    hit_op(2'd3, 10'h004);
    chk("age_4th_resp", resp_valid, 1);
    chk("age_4th_gen_reset", gen_reset, 0);
    req_valid = 1'b1;
    req_hit   = 1'b1;
    req_way   = 2'd1;
    tick();
    chk("age_gen_reset", gen_reset, 1);
    chk("age_ready", req_ready, 0);
    chk("age_enable", enable, 0);
    tick();
    chk("age_back_idle_ready", req_ready, 1);
    chk("age_back_gen_reset", gen_reset, 0);
    tick();
    req_valid = 1'b0;
    chk("age_5th_resp", resp_valid, 1);
    chk("age_5th_way", resp_way, 1);
    tick();
    chk("age_5th_no_gen_reset", gen_reset, 0);
`else
    // Without aging, the 4th and 5th hits go straight back to IDLE
    do_reset();
    for (int n = 0; n < 5; n++) begin
      hit_op(2'(n), 10'(n));
      chk("noage_resp", resp_valid, 1);
      tick();
      chk("noage_gen_reset", gen_reset, 0);
      chk("noage_ready", req_ready, 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
